vga_overlay_compositor: RTL and testbench

VGA_OVERLAY_COMPOSITOR -- requirements
Module: vga_overlay_compositor

---
 rtl/vga_pkg.sv | 50 +++++
 rtl/vga_layer_window.sv | 72 +++++++
 rtl/vga_overlay_compositor.sv | 158 +++++++++++++++
 tb/tb_vga_overlay_compositor.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA overlay compositor.
// Timing defaults, config field codes and pipeline bundles.
package vga_pkg;

  localparam int H_ACT_D = 640;
  localparam int H_FP_D  = 16;
  localparam int H_SYN_D = 96;
  localparam int H_BP_D  = 48;
  localparam int V_ACT_D = 480;
  localparam int V_FP_D  = 10;
  localparam int V_SYN_D = 2;
  localparam int V_BP_D  = 33;

  localparam int ADDR_W = 19;

  typedef enum logic [2:0] {
    FLD_X0 = 3'd0,
    FLD_Y0 = 3'd1,
    FLD_W  = 3'd2,
    FLD_H  = 3'd3,
    FLD_EN = 3'd4
  } cfg_field_e;

  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] y0;
    logic [9:0] w;
    logic [9:0] h;
    logic       en;
  } win_t;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       fr;
    logic [9:0] col;
    logic [8:0] row;
  } tim_t;

  localparam tim_t TIM_RST = '{
    hs:  1'b1,
    vs:  1'b1,
    de:  1'b0,
    fr:  1'b0,
    col: 10'd0,
    row: 9'd0
  };

endpackage

// File: rtl/vga_layer_window.sv
// One overlay layer: shadow/live window registers,
// hit compare and raster-order ROM address counter.
module vga_layer_window
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [2:0]        field,
  input  logic [9:0]        data,
  input  logic              frame_start,
  input  logic [9:0]        col,
  input  logic [9:0]        row,
  output logic              hit,
  output logic [ADDR_W-1:0] addr
);

  win_t              shadow;
  win_t              live;
  win_t              act;
  logic [ADDR_W-1:0] cnt;
  logic [10:0]       x_end;
  logic [10:0]       y_end;
  logic              in_x;
  logic              in_y;

  // shadow takes writes; live snapshots shadow at frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      live   <= '0;
    end else begin
      if (frame_start)
        live <= shadow;
      if (we) begin
        case (cfg_field_e'(field))
          FLD_X0:  shadow.x0 <= data;
          FLD_Y0:  shadow.y0 <= data;
          FLD_W:   shadow.w  <= data;
          FLD_H:   shadow.h  <= data;
          FLD_EN:  shadow.en <= data[0];
          default: ;
        endcase
      end
    end
  end

  // frame-start pixel already belongs to the new frame,
  // so it compares against the set being loaded
  always_comb begin
    act   = frame_start ? shadow : live;
    x_end = {1'b0, act.x0} + {1'b0, act.w};
    y_end = {1'b0, act.y0} + {1'b0, act.h};
    in_x  = ({1'b0, col} >= {1'b0, act.x0})
         && ({1'b0, col} < x_end);
    in_y  = ({1'b0, row} >= {1'b0, act.y0})
         && ({1'b0, row} < y_end);
    hit   = act.en && in_x && in_y;
    addr  = frame_start ? '0 : cnt;
  end

  // address advances once per hit pixel, restarts per frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (hit)
      cnt <= addr + 1'b1;
    else if (frame_start)
      cnt <= '0;
  end

endmodule

// File: rtl/vga_overlay_compositor.sv
// VGA timing plus N prioritised overlay layers over a
// background index; all outputs share one pipeline delay.
module vga_overlay_compositor
  import vga_pkg::*;
#(
  parameter int H_ACT    = H_ACT_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYN    = H_SYN_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACT    = V_ACT_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYN    = V_SYN_D,
  parameter int V_BP     = V_BP_D,
  parameter int N_LAYERS = 4,
  parameter int IDX_W    = 8,
  parameter int ROM_LAT  = 1,
  parameter int TRANSP   = 0
) (
  input  logic                       iVGA_CLK,
  input  logic                       iRST_n,
  input  logic                       cfg_we,
  input  logic [(N_LAYERS>1 ? $clog2(N_LAYERS) : 1)-1:0]
                                     cfg_layer,
  input  logic [2:0]                 cfg_field,
  input  logic [9:0]                 cfg_data,
  input  logic [IDX_W-1:0]           bg_idx,
  input  logic [N_LAYERS*IDX_W-1:0]  layer_idx,
  output logic [N_LAYERS*ADDR_W-1:0] layer_addr,
  output logic [IDX_W-1:0]           pix_idx,
  output logic                       oHS,
  output logic                       oVS,
  output logic                       oBLANK_n,
  output logic                       oFRAME,
  output logic [9:0]                 oCOL,
  output logic [8:0]                 oROW
);

  localparam int LW = N_LAYERS > 1 ? $clog2(N_LAYERS) : 1;
  localparam int D  = ROM_LAT + 2;

  localparam logic [9:0] H_MAX =
    10'(H_ACT + H_FP + H_SYN + H_BP - 1);
  localparam logic [9:0] V_MAX =
    10'(V_ACT + V_FP + V_SYN + V_BP - 1);
  localparam logic [9:0] H_END = 10'(H_ACT);
  localparam logic [9:0] V_END = 10'(V_ACT);
  localparam logic [9:0] HS_B  = 10'(H_ACT + H_FP);
  localparam logic [9:0] HS_E  = 10'(H_ACT + H_FP + H_SYN);
  localparam logic [9:0] VS_B  = 10'(V_ACT + V_FP);
  localparam logic [9:0] VS_E  = 10'(V_ACT + V_FP + V_SYN);

  logic [9:0]          hc;
  logic [9:0]          vc;
  logic                frame_start;
  tim_t                tim_raw;
  tim_t                tim_pipe [D];
  logic [N_LAYERS-1:0] hit;
  logic [N_LAYERS-1:0] hit_pipe [ROM_LAT+1];
  logic [ADDR_W-1:0]   addr   [N_LAYERS];
  logic [ADDR_W-1:0]   addr_q [N_LAYERS];
  logic [IDX_W-1:0]    pix_nxt;

  // raster counters: hc wraps per line, vc per frame
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_MAX) begin
      hc <= '0;
      vc <= (vc == V_MAX) ? '0 : vc + 1'b1;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  // raw timing bundle for the current counter position
  always_comb begin
    frame_start = (hc == '0) && (vc == '0);
    tim_raw.hs  = !((hc >= HS_B) && (hc < HS_E));
    tim_raw.vs  = !((vc >= VS_B) && (vc < VS_E));
    tim_raw.de  = (hc < H_END) && (vc < V_END);
    tim_raw.fr  = frame_start;
    tim_raw.col = hc;
    tim_raw.row = vc[8:0];
  end

  for (genvar l = 0; l < N_LAYERS; l++) begin : g_layer
    vga_layer_window u_win (
      .clk         (iVGA_CLK),
      .rst_n       (iRST_n),
      .we          (cfg_we && (cfg_layer == LW'(l))),
      .field       (cfg_field),
      .data        (cfg_data),
      .frame_start (frame_start),
      .col         (hc),
      .row         (vc),
      .hit         (hit[l]),
      .addr        (addr[l])
    );
    assign layer_addr[l*ADDR_W +: ADDR_W] = addr_q[l];
  end

  // stage 1: present ROM addresses, zero when not hit
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int l = 0; l < N_LAYERS; l++)
        addr_q[l] <= '0;
    end else begin
      for (int l = 0; l < N_LAYERS; l++)
        addr_q[l] <= hit[l] ? addr[l] : '0;
    end
  end

  // delay timing and hit flags to meet the ROM data
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      for (int k = 0; k < D; k++)
        tim_pipe[k] <= TIM_RST;
      for (int k = 0; k <= ROM_LAT; k++)
        hit_pipe[k] <= '0;
    end else begin
      tim_pipe[0] <= tim_raw;
      for (int k = 1; k < D; k++)
        tim_pipe[k] <= tim_pipe[k-1];
      hit_pipe[0] <= hit;
      for (int k = 1; k <= ROM_LAT; k++)
        hit_pipe[k] <= hit_pipe[k-1];
    end
  end

  // lowest-numbered opaque hit wins, else background
  always_comb begin
    pix_nxt = bg_idx;
    for (int l = N_LAYERS - 1; l >= 0; l--) begin
      if (hit_pipe[ROM_LAT][l] &&
          layer_idx[l*IDX_W +: IDX_W] != IDX_W'(TRANSP))
        pix_nxt = layer_idx[l*IDX_W +: IDX_W];
    end
    if (!tim_pipe[ROM_LAT].de)
      pix_nxt = '0;
  end

  // final stage: register the composited index
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n)
      pix_idx <= '0;
    else
      pix_idx <= pix_nxt;
  end

  assign oHS      = tim_pipe[D-1].hs;
  assign oVS      = tim_pipe[D-1].vs;
  assign oBLANK_n = tim_pipe[D-1].de;
  assign oFRAME   = tim_pipe[D-1].fr;
  assign oCOL     = tim_pipe[D-1].col;
  assign oROW     = tim_pipe[D-1].row;

endmodule

// File: tb/tb_vga_overlay_compositor.sv
// Directed bench for vga_overlay_compositor on a
// shrunken 48x32 raster (32x24 active).
module tb_vga_overlay_compositor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_layer;
  logic [2:0]  cfg_field;
  logic [9:0]  cfg_data;
  logic [7:0]  bg_idx;
  logic [31:0] layer_idx;
  logic [75:0] layer_addr;
  logic [7:0]  pix_idx;
  logic        oHS, oVS, oBLANK_n, oFRAME;
  logic [9:0]  oCOL;
  logic [8:0]  oROW;

  logic [7:0]  rom_val [4];

  int total = 0;
  int bad   = 0;

  int n_cyc, n_hs, n_vs, n_de;
  int n_want, n_in, n_alt, n_bg, n_nz;
  int a_err, a_top;

  vga_overlay_compositor #(
    .H_ACT(32), .H_FP(4), .H_SYN(6), .H_BP(6),
    .V_ACT(24), .V_FP(2), .V_SYN(2), .V_BP(4),
    .N_LAYERS(4), .IDX_W(8), .ROM_LAT(1), .TRANSP(0)
  ) dut (
    .iVGA_CLK   (clk),
    .iRST_n     (rst_n),
    .cfg_we     (cfg_we),
    .cfg_layer  (cfg_layer),
    .cfg_field  (cfg_field),
    .cfg_data   (cfg_data),
    .bg_idx     (bg_idx),
    .layer_idx  (layer_idx),
    .layer_addr (layer_addr),
    .pix_idx    (pix_idx),
    .oHS        (oHS),
    .oVS        (oVS),
    .oBLANK_n   (oBLANK_n),
    .oFRAME     (oFRAME),
    .oCOL       (oCOL),
    .oROW       (oROW)
  );

  always #5 clk = ~clk;

  // one-cycle ROM returning a fixed index per layer
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++)
      layer_idx[l*8 +: 8] <= rom_val[l];
  end

  task automatic chk(input string tag,
                     input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input int l, input int f,
                    input int d);
    cfg_layer = 2'(l);
    cfg_field = 3'(f);
    cfg_data  = 10'(d);
    cfg_we    = 1'b1;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic scan(input int x0, input int y0,
                      input int w, input int h,
                      input int want, input int alt,
                      input bit mid);
    int g;
    int a;
    int a_next;
    bit inwin;
    bit wrote;
    n_cyc = 0; n_hs = 0; n_vs = 0; n_de = 0;
    n_want = 0; n_in = 0; n_alt = 0;
    n_bg = 0; n_nz = 0; a_err = 0;
    a_next = 1;
    wrote = 1'b0;
    g = 0;
    @(negedge clk);
    while (oFRAME !== 1'b1 && g < 4000) begin
      @(negedge clk);
      g++;
    end
    chk("frame_seen", int'(g < 4000), 1);
    do begin
      cfg_we = 1'b0;
      n_cyc++;
      if (!oHS) n_hs++;
      if (!oVS) n_vs++;
      if (oBLANK_n) n_de++;
      inwin = int'(oCOL) >= x0 && int'(oCOL) < x0 + w
           && int'(oROW) >= y0 && int'(oROW) < y0 + h;
      if (oBLANK_n && int'(pix_idx) == want) begin
        n_want++;
        if (inwin) n_in++;
      end
      if (oBLANK_n && int'(pix_idx) == alt) n_alt++;
      if (oBLANK_n && pix_idx == bg_idx) n_bg++;
      if (!oBLANK_n && pix_idx != 8'd0) n_nz++;
      a = int'(layer_addr[18:0]);
      if (a != 0) begin
        if (a != a_next) a_err++;
        a_next = a + 1;
      end
      if (mid && !wrote && oROW == 9'd12 &&
          oCOL == 10'd0) begin
        cfg_layer = 2'd0;
        cfg_field = 3'd0;
        cfg_data  = 10'd16;
        cfg_we    = 1'b1;
        wrote     = 1'b1;
      end
      @(negedge clk);
    end while (oFRAME !== 1'b1 && n_cyc < 4000);
    cfg_we = 1'b0;
    a_top = a_next - 1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_pix"}, int'(pix_idx), 0);
    chk({tag, "_hs"}, int'(oHS), 1);
    chk({tag, "_vs"}, int'(oVS), 1);
    chk({tag, "_blank"}, int'(oBLANK_n), 0);
    chk({tag, "_frame"}, int'(oFRAME), 0);
    chk({tag, "_addr"}, int'(layer_addr != '0), 0);
    chk({tag, "_col"}, int'(oCOL), 0);
    chk({tag, "_row"}, int'(oROW), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    cfg_we = 1'b0;
    cfg_layer = '0;
    cfg_field = '0;
    cfg_data = '0;
    bg_idx = 8'd9;
    for (int l = 0; l < 4; l++) rom_val[l] = 8'd0;

    repeat (3) @(negedge clk);
    chk_rst("rst");

    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (oFRAME !== 1'b1 && n < 100);
    chk("frame_lat", n, 3);

    // bare raster, background only
    scan(0, 0, 0, 0, 5, 7, 1'b0);
    chk("t1_period", n_cyc, 1536);
    chk("t1_hs_low", n_hs, 192);
    chk("t1_vs_low", n_vs, 96);
    chk("t1_active", n_de, 768);
    chk("t1_bg", n_bg, 768);
    chk("t1_blank_zero", n_nz, 0);

    // single window, 10x10 of index 5
    rom_val[0] = 8'd5;
    wr(0, 0, 4);
    wr(0, 1, 4);
    wr(0, 2, 10);
    wr(0, 3, 10);
    wr(0, 4, 1);
    scan(4, 4, 10, 10, 5, 7, 1'b0);
    chk("t2_hits", n_want, 100);
    chk("t2_inside", n_in, 100);
    chk("t2_bg", n_bg, 668);
    chk("t2_addr_top", a_top, 99);
    chk("t2_addr_order", a_err, 0);
    chk("t2_blank_zero", n_nz, 0);

    // overlap, layer 0 transparent
    rom_val[0] = 8'd0;
    rom_val[1] = 8'd7;
    wr(1, 0, 8);
    wr(1, 1, 8);
    wr(1, 2, 10);
    wr(1, 3, 10);
    wr(1, 4, 1);
    scan(8, 8, 10, 10, 7, 3, 1'b0);
    chk("t3a_l1_hits", n_want, 100);
    chk("t3a_l1_inside", n_in, 100);
    chk("t3a_bg", n_bg, 668);
    chk("t3a_addr_top", a_top, 99);

    // overlap, layer 0 opaque wins
    rom_val[0] = 8'd3;
    scan(4, 4, 10, 10, 3, 7, 1'b0);
    chk("t3b_l0_hits", n_want, 100);
    chk("t3b_l0_inside", n_in, 100);
    chk("t3b_l1_visible", n_alt, 64);
    chk("t3b_bg", n_bg, 604);

    // mid-frame move of layer 0
    rom_val[0] = 8'd5;
    wr(1, 4, 0);
    scan(4, 4, 10, 10, 5, 7, 1'b1);
    chk("t4_cur_hits", n_want, 100);
    chk("t4_cur_inside", n_in, 100);
    chk("t4_l1_off", n_alt, 0);
    scan(16, 4, 10, 10, 5, 7, 1'b0);
    chk("t4_next_hits", n_want, 100);
    chk("t4_next_inside", n_in, 100);
    chk("t4_addr_top", a_top, 99);

    // zero width never hits
    wr(0, 2, 0);
    scan(0, 0, 0, 0, 5, 7, 1'b0);
    chk("t5_hits", n_want, 0);
    chk("t5_addr_top", a_top, 0);
    chk("t5_addr_order", a_err, 0);
    chk("t5_bg", n_bg, 768);

    // reset mid-line
    n = 0;
    while (!(oBLANK_n === 1'b1 && oCOL == 10'd20) &&
           n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach", int'(n < 4000), 1);
    chk("t6_pre_pix", int'(pix_idx), 9);
    rst_n = 1'b0;
    #1;
    chk_rst("t6_now");
    @(negedge clk);
    @(negedge clk);
    chk_rst("t6_held");
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (oFRAME !== 1'b1 && n < 100);
    chk("t6_frame_lat", n, 3);
    chk("t6_start_col", int'(oCOL), 0);
    chk("t6_start_row", int'(oROW), 0);
    scan(0, 0, 0, 0, 5, 7, 1'b0);
    chk("t6_period", n_cyc, 1536);
    chk("t6_cfg_cleared", n_want, 0);
    chk("t6_bg", n_bg, 768);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
